// File: rtl/relay_pkg.sv
// Shared relay encodings: front-end modes, role codes, FSM states.
// Start symbols here are also used by the relay encoder and decoder.
package relay_pkg;

  localparam logic [2:0] MOD_SNIFFER    = 3'b000;
  localparam logic [2:0] MOD_TAG_LISTEN = 3'b001;
  localparam logic [2:0] MOD_TAG_MOD    = 3'b010;
  localparam logic [2:0] MOD_RD_LISTEN  = 3'b011;
  localparam logic [2:0] MOD_RD_MOD     = 3'b100;

  localparam logic [2:0] ROLE_FAKE_READER = 3'b101;
  localparam logic [2:0] ROLE_FAKE_TAG    = 3'b110;
  localparam logic [2:0] ROLE_DEBUG       = 3'b111;

  localparam logic [3:0] DEF_RD_START  = 4'hc;
  localparam logic [3:0] DEF_TAG_START = 4'hf;
  localparam int         DEF_END_SYMS  = 4;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LISTEN,
    ST_PRE,
    ST_MOD
  } relay_state_t;

  function automatic logic [2:0] mode_of(
    input relay_state_t st,
    input logic         reader
  );
    logic [2:0] m;
    m = MOD_SNIFFER;
    unique case (st)
      ST_LISTEN: m = reader ? MOD_RD_LISTEN : MOD_TAG_LISTEN;
      ST_MOD:    m = reader ? MOD_RD_MOD : MOD_TAG_MOD;
      default:   m = MOD_SNIFFER;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/relay_cap_fifo.sv
// Debug capture FIFO: show-ahead read, full/empty from wrap-bit pointers.
// Reset drops the contents by clearing both pointers.
module relay_cap_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/relay_link_ctrl.sv
// Relay link controller: drives front-end mode from the decoded relay
// symbol stream, with inactivity timeout and serial debug capture.
module relay_link_ctrl
  import relay_pkg::*;
#(
  parameter int               SYM_W         = 4,
  parameter int               HIST_SYMS     = 5,
  parameter int               DIV_LOG2      = 4,
  parameter logic [SYM_W-1:0] RD_START      = SYM_W'(DEF_RD_START),
  parameter logic [SYM_W-1:0] TAG_START     = SYM_W'(DEF_TAG_START),
  parameter int               END_SYMS      = DEF_END_SYMS,
  parameter int               TIMEOUT_TICKS = 1024,
  parameter int               CAP_DEPTH     = 32,
  parameter int               HOLDOFF_W     = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       role,
  input  logic             data_in,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic [2:0]       mod_type,
  output logic             tx_gate,
  output logic             ssp_din,
  output logic             cap_overflow,
  output logic [7:0]       frame_cnt
);

  localparam int HW = HIST_SYMS * SYM_W;
  localparam int EW = END_SYMS * SYM_W;
  localparam int AW = (END_SYMS > 1) ? $clog2(END_SYMS) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = (SYM_W > 1) ? $clog2(SYM_W) : 1;

  localparam logic [DIV_LOG2-1:0] TICK_AT =
    DIV_LOG2'(1) << (DIV_LOG2 - 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(END_SYMS - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(SYM_W - 1);

  logic [DIV_LOG2-1:0] div_cnt;
  logic                tick;

  logic                role_rd;
  logic                role_tag;
  logic                active;
  logic                debug;
  logic                sym_take;
  logic [2:0]          role_q;

  logic [HW-1:0]       hist_q;
  logic [HW-1:0]       hist_d;
  logic [AW-1:0]       align_q;
  logic [AW-1:0]       align_d;
  logic [SYM_W-1:0]    start_sym;
  logic                start_hit;
  logic                end_hit;

  relay_state_t        state_q;
  relay_state_t        state_d;
  logic [TW-1:0]       to_cnt_q;
  logic [TW-1:0]       to_cnt_d;
  logic                timeout;
  logic                clr_align;
  logic                frame_done;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [SYM_W-1:0]    fifo_rd;
  logic [HOLDOFF_W-1:0] hold_q;
  logic [BW-1:0]       bit_q;
  logic                shift_en;

  assign role_rd  = (role == ROLE_FAKE_READER);
  assign role_tag = (role == ROLE_FAKE_TAG);
  assign active   = role_rd || role_tag;
  assign debug    = (role == ROLE_DEBUG);
  assign sym_take = active && sym_valid;

  assign tick = (div_cnt == TICK_AT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Next history/align forwarded so a symbol landing on a tick is seen.
  always_comb begin
    hist_d  = hist_q;
    align_d = align_q;
    if (sym_take) begin
      hist_d  = {hist_q[HW-SYM_W-1:0], sym_in};
      align_d = (align_q == ALIGN_LAST) ? '0 : align_q + 1'b1;
    end
  end

  assign start_sym = role_rd ? RD_START : TAG_START;
  assign start_hit = (hist_d == HW'(start_sym));
  assign end_hit   = (hist_d[EW-1:0] == '0) && (align_d == '0);

  // Symbols keep a frame alive in MOD; PRE only waits on the pattern.
  assign timeout = tick && (to_cnt_q == TO_LAST) &&
                   !((state_q == ST_MOD) && sym_take);

  always_comb begin
    state_d    = state_q;
    clr_align  = 1'b0;
    frame_done = 1'b0;
    if (!active) begin
      state_d = ST_OFF;
    end else if ((role != role_q) || (state_q == ST_OFF)) begin
      state_d = ST_LISTEN;
    end else begin
      unique case (state_q)
        ST_LISTEN: begin
          if (tick && start_hit) begin
            state_d   = ST_MOD;
            clr_align = 1'b1;
          end else if (data_in) begin
            state_d = ST_PRE;
          end
        end
        ST_PRE: begin
          if (tick && start_hit) begin
            state_d   = ST_MOD;
            clr_align = 1'b1;
          end else if (timeout) begin
            state_d = ST_LISTEN;
          end
        end
        ST_MOD: begin
          if (tick && end_hit) begin
            state_d    = ST_LISTEN;
            frame_done = 1'b1;
          end else if (timeout) begin
            state_d = ST_LISTEN;
          end
        end
        default: state_d = ST_LISTEN;
      endcase
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d != state_q) ||
        !((state_q == ST_PRE) || (state_q == ST_MOD))) begin
      to_cnt_d = '0;
    end else if ((state_q == ST_MOD) && sym_take) begin
      to_cnt_d = '0;
    end else if (tick) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_OFF;
      role_q    <= '0;
      hist_q    <= '0;
      align_q   <= '0;
      to_cnt_q  <= '0;
      mod_type  <= MOD_SNIFFER;
      frame_cnt <= '0;
    end else begin
      state_q  <= state_d;
      role_q   <= role;
      hist_q   <= hist_d;
      align_q  <= clr_align ? '0 : align_d;
      to_cnt_q <= to_cnt_d;
      mod_type <= debug ? MOD_RD_LISTEN : mode_of(state_d, role_rd);
      if (frame_done) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign tx_gate = !((mod_type == MOD_TAG_MOD) ||
                     (mod_type == MOD_RD_MOD));

  relay_cap_fifo #(
    .W     (SYM_W),
    .DEPTH (CAP_DEPTH)
  ) u_cap (
    .clk     (clk),
    .reset   (reset),
    .push    (sym_take),
    .wr_data (sym_in),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_overflow <= 1'b0;
    end else if (sym_take && fifo_full) begin
      cap_overflow <= 1'b1;
    end
  end

  assign shift_en = debug && tick && hold_q[HOLDOFF_W-1];
  assign fifo_pop = shift_en && !fifo_empty && (bit_q == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      bit_q   <= '0;
      ssp_din <= 1'b0;
    end else if (!debug) begin
      hold_q  <= '0;
      bit_q   <= '0;
      ssp_din <= 1'b0;
    end else if (tick) begin
      if (!hold_q[HOLDOFF_W-1]) begin
        hold_q <= hold_q + 1'b1;
      end else if (fifo_empty) begin
        ssp_din <= 1'b0;
      end else begin
        ssp_din <= fifo_rd[BIT_LAST - bit_q];
        bit_q   <= (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_relay_link_ctrl.sv
// Directed bench for relay_link_ctrl: mode sequencing, timeout,
// capture overflow, debug serialisation and async reset abort.
module tb_relay_link_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] role;
  logic       data_in;
  logic [3:0] sym_in;
  logic       sym_valid;
  logic [2:0] mod_type;
  logic       tx_gate;
  logic       ssp_din;
  logic       cap_overflow;
  logic [7:0] frame_cnt;

  int vectors = 0;
  int errs    = 0;
  int n;
  int ones;

  always #5 clk = ~clk;

  relay_link_ctrl #(
    .SYM_W         (4),
    .HIST_SYMS     (5),
    .DIV_LOG2      (4),
    .RD_START      (4'hc),
    .TAG_START     (4'hf),
    .END_SYMS      (4),
    .TIMEOUT_TICKS (16),
    .CAP_DEPTH     (8),
    .HOLDOFF_W     (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .role         (role),
    .data_in      (data_in),
    .sym_in       (sym_in),
    .sym_valid    (sym_valid),
    .mod_type     (mod_type),
    .tx_gate      (tx_gate),
    .ssp_din      (ssp_din),
    .cap_overflow (cap_overflow),
    .frame_cnt    (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] v);
    sym_in    = v;
    sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_mod(input string tag, input logic [2:0] exp,
                          input int lim);
    int k = 0;
    while (mod_type !== exp && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, mod_type, exp);
  endtask

  task automatic wait_ssp(input string tag);
    int k = 0;
    while (ssp_din !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, ssp_din, 1);
  endtask

  task automatic expect_word(input string tag, input logic [3:0] w);
    for (int b = 3; b >= 0; b--) begin
      chk(tag, ssp_din, w[b]);
      repeat (16) @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    role      = 3'b000;
    data_in   = 1'b0;
    sym_in    = 4'h0;
    sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mod", mod_type, 3'b000);
    chk("rst_txg", tx_gate, 1);
    chk("rst_ssp", ssp_din, 0);
    chk("rst_ovf", cap_overflow, 0);
    chk("rst_frm", frame_cnt, 0);
    reset = 1'b0;

    // reader role, listen
    @(negedge clk);
    role = 3'b101;
    @(negedge clk);
    chk("rd_listen", mod_type, 3'b011);
    chk("rd_txg", tx_gate, 1);
    chk("rd_frm0", frame_cnt, 0);

    // carrier pre-announce, then start pattern
    data_in = 1'b1;
    @(negedge clk);
    data_in = 1'b0;
    chk("pre_off", mod_type, 3'b000);
    repeat (4) send(4'h0);
    chk("pre_hold", mod_type, 3'b000);
    send(4'hc);
    wait_mod("rd_mod", 3'b100, 40);
    chk("rd_mod_txg", tx_gate, 0);
    repeat (3) send(4'h0);
    chk("rd_mod_unaligned", mod_type, 3'b100);
    send(4'h0);
    wait_mod("rd_end", 3'b011, 40);
    chk("rd_frm1", frame_cnt, 1);
    chk("rd_end_txg", tx_gate, 1);

    // tag role, start then silence until timeout
    role = 3'b110;
    @(negedge clk);
    chk("tag_listen", mod_type, 3'b001);
    sym_in    = 4'hf;
    sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    wait_mod("tag_mod", 3'b010, 40);
    n = 0;
    while (mod_type !== 3'b001 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("tag_timeout_cycles", n, 256);
    chk("tag_timeout_mod", mod_type, 3'b001);
    chk("tag_frm_same", frame_cnt, 1);

    // overflow: fresh FIFO, push depth+3
    reset = 1'b1;
    #1;
    chk("rst2_frm", frame_cnt, 0);
    chk("rst2_ovf", cap_overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("tag_listen2", mod_type, 3'b001);
    for (int i = 8; i < 16; i++) send(4'(i));
    chk("ovf_at_depth", cap_overflow, 0);
    send(4'h1);
    chk("ovf_set", cap_overflow, 1);
    send(4'h2);
    send(4'h3);
    chk("ovf_sticky", cap_overflow, 1);
    chk("ovf_no_mod", mod_type, 3'b001);

    // dump the retained first CAP_DEPTH symbols
    role = 3'b111;
    @(negedge clk);
    chk("dbg_mod", mod_type, 3'b011);
    wait_ssp("dump1_start");
    for (int i = 8; i < 16; i++) expect_word("dump1_bit", 4'(i));
    chk("dump1_tail0", ssp_din, 0);
    repeat (16) @(negedge clk);
    chk("dump1_tail1", ssp_din, 0);

    // capture a,5,3 and dump again
    role = 3'b110;
    @(negedge clk);
    chk("leave_dbg_ssp", ssp_din, 0);
    chk("leave_dbg_mod", mod_type, 3'b001);
    send(4'ha);
    send(4'h5);
    send(4'h3);
    role = 3'b111;
    wait_ssp("dump2_start");
    expect_word("dump2_a", 4'ha);
    expect_word("dump2_5", 4'h5);
    expect_word("dump2_3", 4'h3);
    for (int i = 0; i < 4; i++) begin
      chk("dump2_tail", ssp_din, 0);
      repeat (16) @(negedge clk);
    end
    chk("ovf_kept", cap_overflow, 1);

    // async reset while modulating
    role  = 3'b101;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rd_listen3", mod_type, 3'b011);
    send(4'hc);
    wait_mod("rd_mod3", 3'b100, 40);
    #2;
    reset = 1'b1;
    #1;
    chk("async_mod", mod_type, 3'b000);
    chk("async_txg", tx_gate, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_listen", mod_type, 3'b011);
    role = 3'b111;
    ones = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ssp_din === 1'b1) ones++;
    end
    chk("fifo_empty_after_rst", ones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/relay_link_ctrl.md
Name: relay_link_ctrl

Overview:
- Parametrised successor of the HF relay mode controller.
- Takes the decoded relay symbol stream and drives the analogue front-end mode (`mod_type`) for fake-reader and fake-tag roles.
- Start/end patterns, symbol width and history depth are parameters; adds an inactivity timeout and a FIFO-backed debug capture that serialises to the ARM over `ssp_din`.
- Sits between the relay decoder and the hi_simulate front-end mux, beside the relay encoder.

Parameters:
- SYM_W, 4, bits per decoded symbol
- HIST_SYMS, 5, symbols held in the pattern history shift register
- DIV_LOG2, 4, tick period = 2^DIV_LOG2 clk (0.8475 MHz at 13.56 MHz)
- RD_START, 4'hc, symbol that opens a reader frame
- TAG_START, 4'hf, symbol that opens a tag frame
- END_SYMS, 4, count of consecutive all-zero symbols that closes a frame
- TIMEOUT_TICKS, 1024, ticks in MOD with no symbol before forced return to LISTEN
- CAP_DEPTH, 32, debug FIFO depth in symbols (power of 2)
- HOLDOFF_W, 20, debug serialiser waits 2^(HOLDOFF_W-1) ticks before shifting

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- role  in  3  101 fake reader, 110 fake tag, 111 debug dump, other = sniffer
- data_in  in  1  raw relay line; high pre-announces incoming traffic
- sym_in  in  SYM_W  decoded symbol
- sym_valid  in  1  one-cycle strobe qualifying sym_in
- mod_type  out  3  000 sniffer, 001 tagsim listen, 010 tagsim mod, 011 reader listen, 100 reader mod
- tx_gate  out  1  high when the local encoder may forward relay_raw (mod_type not 010/100)
- ssp_din  out  1  serial debug bit to ARM, MSB first
- cap_overflow  out  1  sticky; a symbol was dropped because the FIFO was full
- frame_cnt  out  8  frames closed since reset, wraps at 255->0

Behaviour:
- Reset values: mod_type=000, tx_gate=1, ssp_din=0, cap_overflow=0, frame_cnt=0. History, FIFO, tick counter, holdoff and timeout counters all cleared.
- Tick: free-running DIV_LOG2-bit counter; tick is asserted when the counter equals 2^(DIV_LOG2-1).
- History: on sym_valid, history <= {history[HIST_SYMS-2:0], sym_in}; align <= align+1 mod END_SYMS. Applies in roles 101/110 only; other roles ignore sym_valid.
- FSM states: OFF, LISTEN, PRE, MOD. mod_type is registered from state and role:
  - OFF -> 000
  - LISTEN -> 011 (reader) / 001 (tag)
  - PRE -> 000
  - MOD -> 100 (reader) / 010 (tag)
- Transitions:
  - Role 101/110 entered from any state -> LISTEN next cycle. Role leaves 101/110 -> OFF next cycle.
  - LISTEN & data_in=1 -> PRE (carrier off in the same cycle data_in is sampled).
  - LISTEN/PRE & tick & history == {zeros, START} -> MOD; align cleared. START is RD_START for 101, TAG_START for 110.
  - MOD & tick & last END_SYMS symbols all zero & align==0 -> LISTEN; frame_cnt increments.
  - MOD & TIMEOUT_TICKS ticks without sym_valid -> LISTEN; frame_cnt does not increment.
  - PRE & TIMEOUT_TICKS ticks with no start pattern -> LISTEN.
- Evaluation order:
  - sym_valid coinciding with tick: the history update is visible to that tick's pattern check (same-cycle forwarding).
  - Role change has priority over every other transition.
- Capture:
  - In roles 101/110, each sym_valid pushes sym_in into the FIFO.
  - Full -> symbol dropped, cap_overflow <= 1 (cleared only by reset).
- Debug role 111:
  - mod_type forced to 011; data_in ignored.
  - holdoff counter advances on tick until its MSB is set.
  - Then on each tick ssp_din shifts out the current FIFO word MSB first; a new word is popped after SYM_W bits.
  - FIFO empty -> ssp_din=0.
  - Leaving 111 resets holdoff and the bit index; FIFO contents are retained.
- Reset mid-frame aborts MOD immediately (asynchronous) and drops FIFO contents.

Decomposition:
- Package relay_pkg:
  - mod_type encodings (SNIFFER..FAKE_TAG) and role codes
  - FSM state enum
  - default start/end symbol constants, shared with the relay encoder and decoder
- One sub-module: relay_cap_fifo, a synchronous FIFO with full/empty, parametrised SYM_W x CAP_DEPTH.

Test Plan:
- Reset, role=101, no symbols -> mod_type 011 one cycle after role set; tx_gate=1; frame_cnt=0.
- Role 101: data_in pulse, then symbols 0,0,0,0,c -> mod_type 000 during PRE, 100 at next tick after c. Then 0,0,0,0 aligned -> 011, frame_cnt=1.
- Role 110: symbols f then silence for TIMEOUT_TICKS ticks -> 010 then 001, frame_cnt unchanged.
- Role 110: push CAP_DEPTH+3 symbols -> cap_overflow=1; the first CAP_DEPTH symbols are retained.
- Capture 3 symbols a,5,3, switch to 111, run past holdoff -> ssp_din sequence 1010_0101_0011, then 0s.
- Assert reset while in MOD (role 101) -> mod_type 000 asynchronously; after release, LISTEN 011 and FIFO empty.
